// File: rtl/frame_egress_sequencer_pkg.sv
// Shared definitions for the frame egress sequencer.
// Descriptor layout: {rsvd[15], src_onehot[14:11], len[10:0]}.
// The package holds the descriptor field positions, the one-hot state encoding,
// the skid-buffer beat format and a one-hot test helper.
package frame_egress_sequencer_pkg;

  localparam int NPORT         = 4;
  localparam int DESC_RSVD_BIT = 15;
  localparam int DESC_SRC_HI   = 14;
  localparam int DESC_SRC_LO   = 11;
  localparam int DESC_LEN_W    = 11;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_DESC  = 4'b0010,
    ST_XFER  = 4'b0100,
    ST_DRAIN = 4'b1000
  } state_e;

  // One byte of the output stream plus its framing flags.
  typedef struct packed {
    logic       eop;
    logic       sop;
    logic [7:0] data;
  } beat_t;

  function automatic logic is_onehot(input logic [NPORT-1:0] v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/frame_egress_sequencer_skid_buf.sv
// frame_skid_buf: 2-entry valid/ready buffer for {eop, sop, data}.
// A push marks a FIFO pop; the byte itself arrives on din_i one cycle later and
// is either passed straight to the output (buffer empty, downstream ready) or
// written into the buffer. This keeps pop-to-output latency at one cycle.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   push_i                  FIFO pop issued this cycle
//   push_sop_i/push_eop_i   framing flags for the byte being popped
//   din_i                   FIFO data, valid the cycle after push_i
//   out_ready_i             downstream accept
//   out_valid_o/out_beat_o  head of the buffer (or bypassed pending byte)
//   occ_o                   entries stored in the buffer
//   pend_o                  a popped byte is in flight (arrives this cycle)
module frame_skid_buf
  import frame_egress_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       push_sop_i,
  input  logic       push_eop_i,
  input  logic [7:0] din_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output beat_t      out_beat_o,
  output logic [1:0] occ_o,
  output logic       pend_o
);

  logic            pend_q, pend_sop_q, pend_eop_q;
  beat_t [1:0]     mem_q;
  logic            rd_ptr_q, wr_ptr_q;
  logic [1:0]      cnt_q;
  beat_t           pend_beat, head;
  logic            deq, wr, rd;

  always_comb begin
    pend_beat   = {pend_eop_q, pend_sop_q, din_i};
    head        = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : pend_beat;
    out_valid_o = (cnt_q != 2'd0) || pend_q;
    out_beat_o  = out_valid_o ? head : '0;
    deq         = out_valid_o && out_ready_i;
    rd          = deq && (cnt_q != 2'd0);
    // The in-flight byte is stored unless it is consumed through the bypass.
    wr          = pend_q && !(deq && (cnt_q == 2'd0));
    occ_o       = cnt_q;
    pend_o      = pend_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= 1'b0;
      pend_sop_q <= 1'b0;
      pend_eop_q <= 1'b0;
      mem_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      pend_q     <= push_i;
      pend_sop_q <= push_sop_i;
      pend_eop_q <= push_eop_i;
      if (wr) begin
        mem_q[wr_ptr_q] <= pend_beat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, wr} - {1'b0, rd};
    end
  end

endmodule

// File: rtl/frame_egress_sequencer.sv
// frame_egress_sequencer: pops one descriptor, then exactly that frame's bytes,
// and emits them as a valid/ready byte stream with sop/eop and source tag.
// Frames from disabled or oversize sources are drained (bytes popped, nothing
// emitted); malformed descriptors are dropped without touching the data FIFO.
// Ports:
//   clk_sys, rst_sys                     clock, synchronous active-high reset
//   ptr_sfifo_rd/dout/empty              descriptor FIFO (dout valid after pop)
//   sfifo_rd/dout                        data FIFO (dout valid after pop)
//   cfg_port_en                          per-source forward enable, sampled in DESC
//   frm_valid/ready/data/sop/eop/src     output byte stream
//   stat_drop_cnt                        saturating dropped-frame count
//   desc_err                             sticky malformed-descriptor flag
//   busy                                 not idle
module frame_egress_sequencer
  import frame_egress_sequencer_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  output logic             ptr_sfifo_rd,
  input  logic [15:0]      ptr_sfifo_dout,
  input  logic             ptr_sfifo_empty,
  output logic             sfifo_rd,
  input  logic [7:0]       sfifo_dout,
  input  logic [3:0]       cfg_port_en,
  output logic             frm_valid,
  input  logic             frm_ready,
  output logic [7:0]       frm_data,
  output logic             frm_sop,
  output logic             frm_eop,
  output logic [3:0]       frm_src,
  output logic [CNT_W-1:0] stat_drop_cnt,
  output logic             desc_err,
  output logic             busy
);

  localparam logic [DESC_LEN_W:0]   MAX_LEN_V = (DESC_LEN_W+1)'(MAX_LEN);
  localparam logic [DESC_LEN_W-1:0] LEN_ONE   = DESC_LEN_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

  state_e                 state_q;
  logic [DESC_LEN_W-1:0]  len_q, iss_q;
  logic [NPORT-1:0]       src_q;
  logic [CNT_W-1:0]       drop_q;
  logic                   err_q;

  logic                   d_rsvd;
  logic [NPORT-1:0]       d_src;
  logic [DESC_LEN_W-1:0]  d_len;
  logic                   issue_ok, room, push, push_sop, push_eop, last_iss;
  logic                   sb_valid, sb_pend;
  logic [1:0]             sb_occ;
  beat_t                  sb_beat;

  always_comb begin
    d_rsvd   = ptr_sfifo_dout[DESC_RSVD_BIT];
    d_src    = ptr_sfifo_dout[DESC_SRC_HI:DESC_SRC_LO];
    d_len    = ptr_sfifo_dout[DESC_LEN_W-1:0];
    issue_ok = iss_q < len_q;
    last_iss = iss_q == (len_q - LEN_ONE);
    // Credit: stored bytes plus the one in flight may not exceed the 2 entries.
    room     = (sb_occ + {1'b0, sb_pend}) < 2'd2;
    // FIFO pops are decoded from state so a pop's data lands in the next cycle,
    // which is exactly when DESC and the skid buffer consume it.
    ptr_sfifo_rd = (state_q == ST_IDLE) && !ptr_sfifo_empty;
    sfifo_rd     = issue_ok && ((state_q == ST_DRAIN) || ((state_q == ST_XFER) && room));
    push         = (state_q == ST_XFER) && sfifo_rd;
    push_sop     = iss_q == '0;
    push_eop     = last_iss;
    frm_valid    = sb_valid;
    frm_data     = sb_beat.data;
    frm_sop      = sb_beat.sop;
    frm_eop      = sb_beat.eop;
    frm_src      = src_q;
    stat_drop_cnt = drop_q;
    desc_err     = err_q;
    busy         = state_q != ST_IDLE;
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      iss_q   <= '0;
      src_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (!ptr_sfifo_empty) state_q <= ST_DESC;
        ST_DESC: begin
          len_q <= d_len;
          src_q <= d_src;
          iss_q <= '0;
          if (d_rsvd || !is_onehot(d_src) || (d_len == '0)) begin
            err_q <= 1'b1;
            if (drop_q != CNT_MAX) drop_q <= drop_q + CNT_ONE;
            state_q <= ST_IDLE;
          end else if (({1'b0, d_len} > MAX_LEN_V) || ((d_src & cfg_port_en) == '0)) begin
            if (drop_q != CNT_MAX) drop_q <= drop_q + CNT_ONE;
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_XFER;
          end
        end
        ST_DRAIN: if (sfifo_rd) begin
          iss_q <= iss_q + LEN_ONE;
          if (last_iss) state_q <= ST_IDLE;
        end
        ST_XFER: begin
          if (sfifo_rd) iss_q <= iss_q + LEN_ONE;
          if (frm_valid && frm_ready && frm_eop) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  frame_skid_buf u_skid (
    .clk_i       (clk_sys),
    .rst_i       (rst_sys),
    .push_i      (push),
    .push_sop_i  (push_sop),
    .push_eop_i  (push_eop),
    .din_i       (sfifo_dout),
    .out_ready_i (frm_ready),
    .out_valid_o (sb_valid),
    .out_beat_o  (sb_beat),
    .occ_o       (sb_occ),
    .pend_o      (sb_pend)
  );

endmodule

// File: tb/tb_frame_egress_sequencer.sv
module tb_frame_egress_sequencer;

  localparam int TB_CNT_W = 3;
  localparam int DROP_MAX = (1 << TB_CNT_W) - 1;

  logic                clk_sys, rst_sys;
  logic                ptr_sfifo_rd, ptr_sfifo_empty, sfifo_rd;
  logic [15:0]         ptr_sfifo_dout;
  logic [7:0]          sfifo_dout;
  logic [3:0]          cfg_port_en;
  logic                frm_valid, frm_ready, frm_sop, frm_eop, desc_err, busy;
  logic [7:0]          frm_data;
  logic [3:0]          frm_src;
  logic [TB_CNT_W-1:0] stat_drop_cnt;

  frame_egress_sequencer #(.MAX_LEN(1518), .CNT_W(TB_CNT_W)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .ptr_sfifo_rd(ptr_sfifo_rd), .ptr_sfifo_dout(ptr_sfifo_dout), .ptr_sfifo_empty(ptr_sfifo_empty),
    .sfifo_rd(sfifo_rd), .sfifo_dout(sfifo_dout), .cfg_port_en(cfg_port_en),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_data(frm_data),
    .frm_sop(frm_sop), .frm_eop(frm_eop), .frm_src(frm_src),
    .stat_drop_cnt(stat_drop_cnt), .desc_err(desc_err), .busy(busy)
  );

  initial begin clk_sys = 0; forever #5 clk_sys = ~clk_sys; end

  // ---------------- upstream FIFO models ----------------
  logic [15:0] pq[$];
  logic [7:0]  dq[$];

  always @(posedge clk_sys) begin
    if (rst_sys) begin
      pq.delete(); dq.delete();
      ptr_sfifo_empty <= 1'b1;
    end else begin
      if (ptr_sfifo_rd && pq.size() > 0) ptr_sfifo_dout <= pq.pop_front();
      if (sfifo_rd && dq.size() > 0) sfifo_dout <= dq.pop_front();
      ptr_sfifo_empty <= (pq.size() == 0);
    end
  end

  // ---------------- reference model state ----------------
  logic [14:0] exp_q[$];   // {src, eop, sop, data} per forwarded byte
  bit          kind_q[$];  // per expected pop: 1 = forwarded, 0 = drained
  int exp_drop, exp_pops, tot_pops, n_cmp, n_bad;
  bit exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = malformed, 1 = drained, 2 = forwarded
  function automatic int classify(input bit rsvd, input logic [3:0] src, input int len);
    if (rsvd || $countones(src) != 1 || len == 0) return 0;
    if (len > 1518 || (src & cfg_port_en) == 4'b0) return 1;
    return 2;
  endfunction

  task automatic bump_drop();
    if (exp_drop < DROP_MAX) exp_drop++;
  endtask

  task automatic push_frame(input bit rsvd, input logic [3:0] src, input int len, input bit seq);
    int k;
    logic [7:0] b;
    logic [10:0] l11;
    k = classify(rsvd, src, len);
    if (k == 0) begin
      exp_err = 1; bump_drop();
    end else begin
      if (k == 1) bump_drop();
      for (int i = 0; i < len; i++) begin
        b = seq ? 8'(i) : 8'($urandom);
        dq.push_back(b);
        kind_q.push_back(k == 2);
        if (k == 2) exp_q.push_back({src, (i == len - 1), (i == 0), b});
      end
      exp_pops += len;
    end
    l11 = 11'(len);
    pq.push_back({rsvd, src, l11});
    ptr_sfifo_empty = 1'b0;
  endtask

  // ---------------- ready driver ----------------
  int rmode, ph;
  logic [3:0] pat;
  initial begin
    frm_ready = 0; rmode = 0; ph = 0; pat = 4'b1001;
    forever begin
      @(posedge clk_sys); #1;
      case (rmode)
        0: frm_ready = 1;
        1: begin frm_ready = pat[ph]; ph = (ph + 1) % 4; end
        default: frm_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  int cyc, first_rd, first_vld, run, max_run, last_eop_cyc, last_gap, out_cnt, n_xfer;
  bit hold_pend;
  logic [13:0] held;

  always @(negedge clk_sys) begin
    cyc++;
    if (!rst_sys) begin
      if (hold_pend) check("hold", {frm_valid, frm_src, frm_eop, frm_sop, frm_data}, {1'b1, held});
      hold_pend = frm_valid && !frm_ready;
      held = {frm_src, frm_eop, frm_sop, frm_data};
      if (frm_valid) begin
        run++; if (run > max_run) max_run = run;
        if (first_vld < 0) first_vld = cyc;
      end else run = 0;
      if (ptr_sfifo_rd && last_eop_cyc >= 0) begin last_gap = cyc - last_eop_cyc; last_eop_cyc = -1; end
      if (sfifo_rd) begin
        tot_pops++;
        if (first_rd < 0) first_rd = cyc;
        check("pop_expected", kind_q.size() != 0, 1);
        if (kind_q.size() != 0 && kind_q.pop_front()) out_cnt++;
      end
      if (frm_valid && frm_ready) begin
        n_xfer++; out_cnt--;
        check("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("xfer", {frm_src, frm_eop, frm_sop, frm_data}, exp_q.pop_front());
        if (frm_eop) last_eop_cyc = cyc;
      end
      if (sfifo_rd) check("outstanding", out_cnt <= 2, 1);
    end
  end

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || kind_q.size() != 0 || pq.size() != 0 || busy) && n < 20000) begin
      @(negedge clk_sys); n++;
    end
    check({tag, "_timeout"}, n < 20000, 1);
    check({tag, "_drop"}, stat_drop_cnt, exp_drop);
    check({tag, "_err"}, desc_err, exp_err);
    check({tag, "_pops"}, tot_pops, exp_pops);
  endtask

  task automatic clear_model();
    exp_q.delete(); kind_q.delete();
    exp_drop = 0; exp_err = 0; exp_pops = 0; tot_pops = 0;
    out_cnt = 0; hold_pend = 0; last_eop_cyc = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, n;
    logic [3:0] rs;
    n_cmp = 0; n_bad = 0; cyc = 0; n_xfer = 0; run = 0; max_run = 0; last_gap = -1;
    first_rd = -1; first_vld = -1;
    rst_sys = 1; cfg_port_en = 4'hF; ptr_sfifo_empty = 1; ptr_sfifo_dout = 0; sfifo_dout = 0;
    clear_model();
    repeat (3) @(posedge clk_sys);
    #1 rst_sys = 0;
    @(negedge clk_sys);
    check("rst_valid", frm_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", stat_drop_cnt, 0);
    check("rst_err", desc_err, 0);
    check("rst_rd", sfifo_rd, 0);
    check("rst_ptr_rd", ptr_sfifo_rd, 0);

    // 64-byte counting frame then a len=1 frame from port 2, ready held high
    first_rd = -1; first_vld = -1; max_run = 0; last_eop_cyc = -1; last_gap = -1;
    push_frame(0, 4'b0001, 64, 1);
    push_frame(0, 4'b0100, 1, 0);
    wait_done("t1");
    check("t1_latency", first_vld - first_rd, 1);
    check("t1_run", max_run, 64);
    check("t1_next_desc_gap", last_gap, 1);

    // 100 bytes with ready pattern 1,0,0,1
    rmode = 1; ph = 0;
    push_frame(0, 4'b1000, 100, 0);
    wait_done("t3");
    rmode = 0;

    // disabled source drained, following frame intact
    cfg_port_en = 4'b1101;
    push_frame(0, 4'b0010, 60, 0);
    push_frame(0, 4'b0001, 64, 1);
    wait_done("t4");
    check("t4_drop_one", stat_drop_cnt, 1);

    // malformed descriptors, good frame, oversize frame
    cfg_port_en = 4'b1111;
    push_frame(0, 4'b0001, 0, 0);
    push_frame(1, 4'b0001, 5, 0);
    push_frame(0, 4'b1000, 10, 0);
    wait_done("t5");
    push_frame(0, 4'b0001, 1600, 0);
    wait_done("t5_long");

    // drive the narrow drop counter into saturation
    cfg_port_en = 4'b0000;
    for (int i = 0; i < 4; i++) push_frame(0, 4'b0100, 3, 0);
    wait_done("sat");
    check("sat_value", stat_drop_cnt, DROP_MAX);

    // randomized batches, random backpressure
    rmode = 2;
    for (int b = 0; b < 3; b++) begin
      cfg_port_en = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        rs = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        push_frame(($urandom_range(0, 9) == 0), rs, $urandom_range(0, 40), 0);
      end
      wait_done("rand");
    end
    rmode = 0;

    // reset mid-frame at byte 30
    cfg_port_en = 4'b1111;
    base = n_xfer;
    push_frame(0, 4'b0001, 64, 1);
    n = 0;
    while (n_xfer - base < 30 && n < 2000) begin @(negedge clk_sys); n++; end
    check("rst_mid_reach", n < 2000, 1);
    @(posedge clk_sys); #1;
    rst_sys = 1; clear_model();
    @(posedge clk_sys); #1;
    rst_sys = 0;
    @(negedge clk_sys);
    check("mid_rst_valid", frm_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop", stat_drop_cnt, 0);
    check("mid_rst_err", desc_err, 0);
    push_frame(0, 4'b0010, 20, 1);
    wait_done("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
